// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared types for the rename table and its ROB/CDB interfaces.
//   IW: ROB tag width (ROB depth = 2**IW).
//   cdb_entry_t: one CDB broadcast (valid, rob_id, rd_v).
//   rob_entry_t: one ROB commit (regf_we, rd_s, rd_v).
//   rename_entry_t: per-register rename state (renamed, rob_id); rename_tbl_t holds x0..x31.
package rename_regfile_pkg;
  localparam int IW = 5;
  typedef struct packed {
    logic valid;
    logic [IW-1:0] rob_id;
    logic [31:0] rd_v;
  } cdb_entry_t;
  typedef struct packed {
    logic regf_we;
    logic [4:0] rd_s;
    logic [31:0] rd_v;
  } rob_entry_t;
  typedef struct packed {
    logic renamed;
    logic [IW-1:0] rob_id;
  } rename_entry_t;
  typedef rename_entry_t [31:0] rename_tbl_t;
endpackage

// File: rtl/rename_ckpt_store.sv
// rename_ckpt_store: NCKPT snapshots of the rename table with a free-list bitmap.
//   clk, rst: clock, synchronous active-high reset; flush frees every snapshot.
//   alloc/snap_in: capture snap_in into the lowest free slot (ignored when full, restoring or flushing).
//   alloc_id/full: slot the next alloc would use; all slots busy.
//   restore/restore_id/snap_out: snapshot read out; every slot allocated after it is freed.
//   free/free_id: release one slot.
module rename_ckpt_store import rename_regfile_pkg::*; #(
  parameter int NCKPT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic alloc,
  input  rename_tbl_t snap_in,
  output logic [$clog2(NCKPT)-1:0] alloc_id,
  output logic full,
  input  logic restore,
  input  logic [$clog2(NCKPT)-1:0] restore_id,
  output rename_tbl_t snap_out,
  input  logic free,
  input  logic [$clog2(NCKPT)-1:0] free_id
);
  logic [NCKPT-1:0] busy, busy_nxt;
  logic [NCKPT-1:0][NCKPT-1:0] younger;
  rename_tbl_t snap [NCKPT];
  logic do_alloc;
  assign full = &busy;
  assign snap_out = snap[restore_id];
  assign do_alloc = alloc && !full && !restore && !flush;
  always_comb begin
    alloc_id = '0;
    for (int k = NCKPT - 1; k >= 0; k--) alloc_id = busy[k] ? alloc_id : k[$clog2(NCKPT)-1:0];
  end
  // younger[b][a]: slot a was allocated while b was live, so a restore to b discards a
  always_comb begin
    busy_nxt = busy;
    if (free) busy_nxt[free_id] = 1'b0;
    if (restore) busy_nxt = busy_nxt & ~younger[restore_id];
    if (do_alloc) busy_nxt[alloc_id] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= '0;
      younger <= '0;
    end else begin
      busy <= busy_nxt;
      if (do_alloc) begin
        for (int b = 0; b < NCKPT; b++) younger[b][alloc_id] <= busy[b];
        younger[alloc_id] <= '0;
      end
    end
  end
  always_ff @(posedge clk) if (do_alloc) snap[alloc_id] <= snap_in;
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file plus rename table with operand resolution.
//   clk, rst (sync, active-high), flush: drop all renames, commits still land.
//   disp_*: dispatch group (slot 0 oldest); src*_v/src*_pend: resolved operands or pending tag.
//   rob_rs*_s/_rdy/_v: ROB read-through for renamed sources; cdb_in: result bypass.
//   commit/commit_rob: retirement writes (port 0 oldest).
//   RENAME_CKPT_EN adds ckpt_alloc/id/full/restore/restore_id/free/free_id via rename_ckpt_store.
module rename_regfile import rename_regfile_pkg::*; #(
  parameter int DW = 2,
  parameter int CW = 2,
  parameter int CDB_PORTS = 3
`ifdef RENAME_CKPT_EN
  , parameter int NCKPT = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
`ifdef RENAME_CKPT_EN
  input  logic ckpt_alloc,
  output logic [$clog2(NCKPT)-1:0] ckpt_id,
  output logic ckpt_full,
  input  logic ckpt_restore,
  input  logic [$clog2(NCKPT)-1:0] ckpt_restore_id,
  input  logic ckpt_free,
  input  logic [$clog2(NCKPT)-1:0] ckpt_free_id,
`endif
  input  logic [DW-1:0] disp_valid,
  input  logic [DW-1:0][4:0] disp_rd,
  input  logic [DW-1:0][IW-1:0] disp_rob,
  input  logic [DW-1:0][4:0] disp_rs1,
  input  logic [DW-1:0][4:0] disp_rs2,
  output logic [DW-1:0][IW-1:0] rob_rs1_s,
  output logic [DW-1:0][IW-1:0] rob_rs2_s,
  input  logic [DW-1:0] rob_rs1_rdy,
  input  logic [DW-1:0] rob_rs2_rdy,
  input  logic [DW-1:0][31:0] rob_rs1_v,
  input  logic [DW-1:0][31:0] rob_rs2_v,
  input  cdb_entry_t [CDB_PORTS-1:0] cdb_in,
  input  rob_entry_t [CW-1:0] commit,
  input  logic [CW-1:0][IW-1:0] commit_rob,
  output logic [DW-1:0][31:0] src1_v,
  output logic [DW-1:0][31:0] src2_v,
  output logic [DW-1:0] src1_pend,
  output logic [DW-1:0] src2_pend
);
  logic [31:0][31:0] data;
  rename_tbl_t tbl, tbl_nxt;
  // {hit, tag} of the youngest older slot in the group writing s
  function automatic logic [IW:0] older_fwd(input int i, input logic [4:0] s, input logic [DW-1:0] v,
                                            input logic [DW-1:0][4:0] rd, input logic [DW-1:0][IW-1:0] rob);
    older_fwd = '0;
    for (int j = 0; j < i; j++) if (v[j] && rd[j] == s) older_fwd = {1'b1, rob[j]};
  endfunction
  // {pend, value}; an in-group producer hides the regfile and ROB entirely
  function automatic logic [32:0] resolve(input logic [4:0] s, input rename_entry_t e, input logic [31:0] d,
                                          input logic rdy, input logic [31:0] rv,
                                          input cdb_entry_t [CDB_PORTS-1:0] cdb, input logic [IW:0] fwd);
    logic [IW-1:0] tag;
    logic hit;
    logic [31:0] hv;
    tag = fwd[IW] ? fwd[IW-1:0] : e.rob_id;
    hit = 1'b0;
    hv = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) if (cdb[p].valid && cdb[p].rob_id == tag) {hit, hv} = {1'b1, cdb[p].rd_v};
    if (s == 5'd0) return '0;
    if (fwd[IW]) return hit ? {1'b0, hv} : {1'b1, 32'(tag)};
    if (!e.renamed) return {1'b0, d};
    return hit ? {1'b0, hv} : rdy ? {1'b0, rv} : {1'b1, 32'(tag)};
  endfunction
  // a commit only un-renames a register still owned by the committing tag
  function automatic rename_tbl_t clr_commits(input rename_tbl_t t, input rob_entry_t [CW-1:0] c,
                                              input logic [CW-1:0][IW-1:0] r);
    clr_commits = t;
    for (int k = 0; k < CW; k++)
      if (c[k].regf_we && c[k].rd_s != 5'd0 && t[c[k].rd_s].rob_id == r[k]) clr_commits[c[k].rd_s].renamed = 1'b0;
  endfunction
  for (genvar g = 0; g < DW; g++) begin : g_slot
    assign rob_rs1_s[g] = tbl[disp_rs1[g]].rob_id;
    assign rob_rs2_s[g] = tbl[disp_rs2[g]].rob_id;
    assign {src1_pend[g], src1_v[g]} = resolve(disp_rs1[g], tbl[disp_rs1[g]], data[disp_rs1[g]], rob_rs1_rdy[g],
      rob_rs1_v[g], cdb_in, older_fwd(g, disp_rs1[g], disp_valid, disp_rd, disp_rob));
    assign {src2_pend[g], src2_v[g]} = resolve(disp_rs2[g], tbl[disp_rs2[g]], data[disp_rs2[g]], rob_rs2_rdy[g],
      rob_rs2_v[g], cdb_in, older_fwd(g, disp_rs2[g], disp_valid, disp_rd, disp_rob));
  end
`ifdef RENAME_CKPT_EN
  rename_tbl_t snap_out;
  rename_ckpt_store #(.NCKPT(NCKPT)) u_ckpt (
    .clk(clk), .rst(rst), .flush(flush), .alloc(ckpt_alloc), .snap_in(tbl_nxt), .alloc_id(ckpt_id),
    .full(ckpt_full), .restore(ckpt_restore), .restore_id(ckpt_restore_id), .snap_out(snap_out),
    .free(ckpt_free), .free_id(ckpt_free_id)
  );
`endif
  always_comb begin
    tbl_nxt = clr_commits(tbl, commit, commit_rob);
    for (int i = 0; i < DW; i++) if (disp_valid[i] && disp_rd[i] != 5'd0) tbl_nxt[disp_rd[i]] = {1'b1, disp_rob[i]};
`ifdef RENAME_CKPT_EN
    if (ckpt_restore) tbl_nxt = clr_commits(snap_out, commit, commit_rob);
`endif
    if (flush) tbl_nxt = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      tbl <= '0;
    end else begin
      for (int k = 0; k < CW; k++) if (commit[k].regf_we && commit[k].rd_s != 5'd0) data[commit[k].rd_s] <= commit[k].rd_v;
      tbl <= tbl_nxt;
    end
  end
endmodule
